// File: rtl/adder_pkg.sv
// Shared types and default geometry for the pipelined adder/subtractor.
package adder_pkg;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_e;

    localparam int DEFAULT_WIDTH  = 32;
    localparam int DEFAULT_STAGES = 4;

endpackage

// File: rtl/rca_slice.sv
// Combinational SW-bit ripple-carry slice. Also exposes the carry into its
// top bit so the most significant slice can derive signed overflow.
module rca_slice
    import adder_pkg::*;
#(
    parameter int SW = 8
) (
    input  logic [SW-1:0] x,
    input  logic [SW-1:0] y,
    input  logic          ci,
    output logic [SW-1:0] s,
    output logic          co,
    output logic          c_msb_in
);

    logic [SW:0] c;

    // Bit-serial ripple: c[i] is the carry into bit i.
    always_comb begin
        c    = '0;
        s    = '0;
        c[0] = ci;
        for (int i = 0; i < SW; i++) begin
            s[i]   = x[i] ^ y[i] ^ c[i];
            c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
        end
    end

    assign co       = c[SW];
    assign c_msb_in = c[SW-1];

endmodule

// File: rtl/pipe_adder.sv
// Pipelined ripple-carry adder/subtractor. Stage k resolves slice k of the
// operands using the carry registered by stage k-1; unconsumed operand slices
// ride forward in skew registers and finished sum slices ride forward in
// deskew registers so a whole beat leaves the last stage together.
module pipe_adder
    import adder_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int STAGES = DEFAULT_STAGES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  op_e              op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int SW = WIDTH / STAGES;

    if ((STAGES < 1) || (STAGES > WIDTH) || ((WIDTH % STAGES) != 0)) begin : g_bad_geometry
        $error("pipe_adder: WIDTH must be a multiple of STAGES and 1 <= STAGES <= WIDTH");
    end

    logic                          advance;
    logic             [WIDTH-1:0]  b_eff;
    logic                          cin_eff;

    // Per-stage pipeline state.
    logic [STAGES-1:0]             vld_q,  vld_d;
    logic [STAGES-1:0][WIDTH-1:0]  a_q,    a_d;
    logic [STAGES-1:0][WIDTH-1:0]  b_q,    b_d;
    logic [STAGES-1:0][WIDTH-1:0]  sum_q,  sum_d;
    logic [STAGES-1:0]             cy_q,   cy_d;
    logic                          cmsb_q, cmsb_d;

    // Slice datapath wiring.
    logic [STAGES-1:0][SW-1:0]     x_w, y_w, s_w;
    logic [STAGES-1:0]             ci_w, co_w, cm_w;

    // The final stage's operand copies and the non-top slice MSB carries have no
    // reader; folding them here keeps them visibly accounted for.
    logic                          unused_tail;
    assign unused_tail = ^{a_q[STAGES-1], b_q[STAGES-1], cm_w};

    // Subtract is a + ~b + 1; the external carry-in only matters for add.
    assign b_eff   = (op == OP_SUB) ? ~b   : b;
    assign cin_eff = (op == OP_SUB) ? 1'b1 : cin;

    // Global stall: the whole pipe moves only when the output slot frees up.
    assign advance  = !vld_q[STAGES-1] || out_ready;
    assign in_ready = advance;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        if (k == 0) begin : g_first
            assign x_w[k]  = a[SW-1:0];
            assign y_w[k]  = b_eff[SW-1:0];
            assign ci_w[k] = cin_eff;
        end else begin : g_rest
            assign x_w[k]  = a_q[k-1][k*SW +: SW];
            assign y_w[k]  = b_q[k-1][k*SW +: SW];
            assign ci_w[k] = cy_q[k-1];
        end

        rca_slice #(.SW(SW)) u_slice (
            .x        (x_w[k]),
            .y        (y_w[k]),
            .ci       (ci_w[k]),
            .s        (s_w[k]),
            .co       (co_w[k]),
            .c_msb_in (cm_w[k])
        );
    end

    // Next state: hold everything, or shift every stage (bubbles included) by one.
    always_comb begin
        vld_d  = vld_q;
        a_d    = a_q;
        b_d    = b_q;
        sum_d  = sum_q;
        cy_d   = cy_q;
        cmsb_d = cmsb_q;
        if (advance) begin
            vld_d[0]          = in_valid;
            a_d[0]            = a;
            b_d[0]            = b_eff;
            sum_d[0]          = '0;
            sum_d[0][SW-1:0]  = s_w[0];
            cy_d[0]           = co_w[0];
            for (int k = 1; k < STAGES; k++) begin
                vld_d[k]              = vld_q[k-1];
                a_d[k]                = a_q[k-1];
                b_d[k]                = b_q[k-1];
                sum_d[k]              = sum_q[k-1];
                sum_d[k][k*SW +: SW]  = s_w[k];
                cy_d[k]               = co_w[k];
            end
            cmsb_d = cm_w[STAGES-1];
        end
    end

    // Pipeline registers; reset clears data too so outputs read zero after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q  <= '0;
            a_q    <= '0;
            b_q    <= '0;
            sum_q  <= '0;
            cy_q   <= '0;
            cmsb_q <= 1'b0;
        end else begin
            vld_q  <= vld_d;
            a_q    <= a_d;
            b_q    <= b_d;
            sum_q  <= sum_d;
            cy_q   <= cy_d;
            cmsb_q <= cmsb_d;
        end
    end

    assign out_valid = vld_q[STAGES-1];
    assign sum       = sum_q[STAGES-1];
    assign cout      = cy_q[STAGES-1];
    assign ovf       = cy_q[STAGES-1] ^ cmsb_q;

endmodule

// File: tb/tb_pipe_adder.sv
// Bench for pipe_adder: three geometries (32/4, 32/1, 64/8) share one stimulus
// bus; sel picks which one is driven and observed. A queue of expected beats,
// each with its due cycle, models latency, stalls and results arithmetically.
module tb_pipe_adder;
    import adder_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [63:0] a_in, b_in;
    logic        cin_in;
    op_e         op_in;
    logic        out_ready;
    int          sel;

    always #5 clk = ~clk;

    logic        iv0, iv1, iv2;
    logic        ir0, ir1, ir2, ov0, ov1, ov2, co0, co1, co2, of0, of1, of2;
    logic [31:0] s0, s1;
    logic [63:0] s2;

    assign iv0 = in_valid && (sel == 0);
    assign iv1 = in_valid && (sel == 1);
    assign iv2 = in_valid && (sel == 2);

    pipe_adder #(.WIDTH(32), .STAGES(4)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv0), .in_ready(ir0),
        .a(a_in[31:0]), .b(b_in[31:0]), .cin(cin_in), .op(op_in),
        .out_valid(ov0), .out_ready(out_ready), .sum(s0), .cout(co0), .ovf(of0));

    pipe_adder #(.WIDTH(32), .STAGES(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1),
        .a(a_in[31:0]), .b(b_in[31:0]), .cin(cin_in), .op(op_in),
        .out_valid(ov1), .out_ready(out_ready), .sum(s1), .cout(co1), .ovf(of1));

    pipe_adder #(.WIDTH(64), .STAGES(8)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv2), .in_ready(ir2),
        .a(a_in), .b(b_in), .cin(cin_in), .op(op_in),
        .out_valid(ov2), .out_ready(out_ready), .sum(s2), .cout(co2), .ovf(of2));

    logic        ir_obs, ov_obs, co_obs, of_obs;
    logic [63:0] sum_obs;

    always_comb begin
        ir_obs  = ir0;
        ov_obs  = ov0;
        sum_obs = {32'b0, s0};
        co_obs  = co0;
        of_obs  = of0;
        case (sel)
            1: begin ir_obs = ir1; ov_obs = ov1; sum_obs = {32'b0, s1}; co_obs = co1; of_obs = of1; end
            2: begin ir_obs = ir2; ov_obs = ov2; sum_obs = s2;          co_obs = co2; of_obs = of2; end
            default: ;
        endcase
    end

    typedef struct {
        logic [63:0] sum;
        logic        cout;
        logic        ovf;
        int          due;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   errs = 0;
    int   checks = 0;
    int   w_cur, s_cur;
    int   rdy_mode = 0;
    int   stall_from = 0;
    int   stall_len = 0;
    bit   got_in;

    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s (sel=%0d cyc=%0d): got %0h want %0h", tag, sel, cyc, obs, exp);
        end
    endtask

    // Reference: plain wide arithmetic on the effective operands.
    function automatic exp_t model(input logic [63:0] av, input logic [63:0] bv,
                                   input logic ci, input op_e o, input int w);
        exp_t        e;
        logic [63:0] msk, am, bx;
        logic [64:0] full;
        msk   = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
        am    = av & msk;
        bx    = (o == OP_SUB) ? (~bv & msk) : (bv & msk);
        full  = {1'b0, am} + {1'b0, bx} + ((o == OP_SUB) ? 65'd1 : {64'd0, ci});
        e.sum  = full[63:0] & msk;
        e.cout = full[w];
        e.ovf  = (am[w-1] == bx[w-1]) && (e.sum[w-1] != am[w-1]);
        e.due  = 0;
        return e;
    endfunction

    // One clock: check outputs at the falling edge, update the model, step.
    task automatic tick();
        bit   ev, er;
        exp_t e;
        @(negedge clk);
        ev = (q.size() != 0) && (cyc >= q[0].due);
        er = out_ready || !ev;
        chk("out_valid", 64'(ov_obs), 64'(ev));
        chk("in_ready",  64'(ir_obs), 64'(er));
        if (ev) begin
            chk("sum",  sum_obs,      q[0].sum);
            chk("cout", 64'(co_obs),  64'(q[0].cout));
            chk("ovf",  64'(of_obs),  64'(q[0].ovf));
        end
        if (!er) begin
            foreach (q[i]) if (q[i].due > cyc) q[i].due++;
        end
        if (ev && out_ready) void'(q.pop_front());
        got_in = in_valid && er;
        if (got_in) begin
            e     = model(a_in, b_in, cin_in, op_in, w_cur);
            e.due = cyc + s_cur;
            q.push_back(e);
        end
        @(posedge clk);
        #1;
        case (rdy_mode)
            1:       out_ready = ($urandom_range(3) != 0);
            2:       out_ready = !((cyc >= stall_from) && (cyc < stall_from + stall_len));
            default: out_ready = 1'b1;
        endcase
    endtask

    task automatic send(input logic [63:0] av, input logic [63:0] bv, input logic c, input op_e o);
        a_in = av; b_in = bv; cin_in = c; op_in = o; in_valid = 1'b1;
        for (int n = 0; n < 50; n++) begin
            tick();
            if (got_in) break;
        end
        chk("send_accepted", 64'(got_in), 64'd1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        rdy_mode  = 0;
        for (int n = 0; n < 100; n++) begin
            if (q.size() == 0) break;
            tick();
        end
        chk("drain_empty", 64'(q.size()), 64'd0);
        tick();
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_out_valid", 64'(ov_obs), 64'd0);
        chk("rst_sum",       sum_obs,     64'd0);
        chk("rst_cout",      64'(co_obs), 64'd0);
        chk("rst_ovf",       64'(of_obs), 64'd0);
        chk("rst_in_ready",  64'(ir_obs), 64'd1);
        q.delete();
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic run_dut(input int s, input int w, input int st);
        logic [63:0] msk, mx;
        sel = s; w_cur = w; s_cur = st;
        msk = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
        mx  = msk >> 1;
        rdy_mode = 0; out_ready = 1'b1;
        #1;
        // Directed corners, then back-to-back at full throughput.
        send(64'd35000, 64'd35000, 1'b0, OP_ADD);
        drain();
        send(msk,        64'd0, 1'b1, OP_ADD);
        send(mx,         64'd1, 1'b0, OP_ADD);
        send(mx + 64'd1, msk,   1'b0, OP_ADD);
        send(64'd5,      64'd7, 1'b1, OP_SUB);
        send(64'd7,      64'd5, 1'b1, OP_SUB);
        drain();
        // Six-beat stream with a three-cycle consumer stall in the middle.
        rdy_mode = 2; stall_from = cyc + st + 2; stall_len = 3;
        for (int i = 0; i < 6; i++) send(64'(i), 64'(i * 3), 1'b0, OP_ADD);
        drain();
        // Random traffic with random backpressure.
        rdy_mode = 1;
        for (int n = 0; n < 40; n++) begin
            in_valid = ($urandom_range(9) < 7);
            a_in     = {$urandom, $urandom};
            b_in     = {$urandom, $urandom};
            cin_in   = $urandom_range(1);
            op_in    = op_e'($urandom_range(1));
            tick();
        end
        in_valid = 1'b0;
        drain();
        // Reset with beats in flight; nothing stale may appear afterwards.
        for (int i = 0; i < 3; i++) send({$urandom, $urandom}, {$urandom, $urandom}, 1'b0, OP_ADD);
        do_reset();
        for (int n = 0; n < st + 2; n++) tick();
        send(64'd1, 64'd2, 1'b0, OP_ADD);
        drain();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; a_in = '0; b_in = '0;
        cin_in = 1'b0; op_in = OP_ADD; out_ready = 1'b1; sel = 0;
        w_cur = 32; s_cur = 4;
        #2;
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #1;
            chk("init_out_valid", 64'(ov_obs), 64'd0);
            chk("init_sum",       sum_obs,     64'd0);
            chk("init_in_ready",  64'(ir_obs), 64'd1);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        run_dut(0, 32, 4);
        run_dut(1, 32, 1);
        run_dut(2, 64, 8);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
